rsa_pipeline_top: RTL and testbench

Top-level RSA byte-stream engine. On `start` it encrypts a fixed on-chip message, one byte at a time, using square-and-multiply modular exponentiation. Results go to an internal result RAM. It then streams the results out as bytes with a read strobe, raising status flags for zero result, communication phase and completion.

---
 rtl/rsa_pkg.sv | 22 ++
 rtl/rsa_modmul.sv | 17 +
 rtl/rsa_pipeline_top.sv | 159 +++++++++++++++
 tb/tb_rsa_pipeline_top.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and default constants for the RSA byte-stream engine.
package rsa_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] prod_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SQR,
    ST_MUL,
    ST_STORE,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_DONE
  } state_t;

  localparam int DEF_MOD_N = 253;
  localparam int DEF_EXP_E = 7;
  localparam int DEF_EXP_D = 63;

endpackage

// File: rtl/rsa_modmul.sv
// Combinational modular multiply: y = (a * b) mod MOD_N on a 16-bit product.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int MOD_N = DEF_MOD_N
) (
  input  byte_t a,
  input  byte_t b,
  output byte_t y
);

  prod_t prod;

  assign prod = prod_t'(a) * prod_t'(b);
  assign y    = byte_t'(prod % prod_t'(MOD_N));

endmodule

// File: rtl/rsa_pipeline_top.sv
// RSA byte-stream engine: square-and-multiply over an on-chip message, then streams results.
// Optional build macro RSA_DECRYPT_EN selects the private exponent EXP_D instead of EXP_E.
module rsa_pipeline_top
  import rsa_pkg::*;
#(
  parameter int N_BYTES = 16,
  parameter int MOD_N   = DEF_MOD_N,
  parameter int EXP_E   = DEF_EXP_E,
  parameter int EXP_D   = DEF_EXP_D
) (
  input  logic       clk_FPGA,
  input  logic       reset,
  input  logic       start,
  output logic       FlagZero,
  output logic       EndFlag,
  output logic       COMFlag,
  output logic       clk_out,
  output logic [7:0] ReadDataOut
);

  localparam int KW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
`ifdef RSA_DECRYPT_EN
  localparam bit DECRYPT = 1'b1;
`else
  localparam bit DECRYPT = 1'b0;
`endif
  localparam byte_t EXP  = DECRYPT ? byte_t'(EXP_D) : byte_t'(EXP_E);
  localparam logic [KW-1:0] K_LAST = KW'(N_BYTES - 1);

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [2:0]    i_q, i_d;
  byte_t         r_q, r_d, m_q, m_d;
  logic          flag_zero_q, flag_zero_d;
  logic          end_q, end_d;
  logic          com_q, com_d;
  logic          clk_out_q, clk_out_d;
  byte_t         rd_q, rd_d;
  logic          ram_we;
  byte_t         ram_q [N_BYTES];
  byte_t         mm_b, mm_y;

  // One shared multiplier: SQR squares r, MUL multiplies r by the message byte.
  assign mm_b = (state_q == ST_SQR) ? r_q : m_q;

  rsa_modmul #(.MOD_N(MOD_N)) u_modmul (
    .a (r_q),
    .b (mm_b),
    .y (mm_y)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    i_d         = i_q;
    r_d         = r_q;
    m_d         = m_q;
    flag_zero_d = flag_zero_q;
    end_d       = end_q;
    com_d       = com_q;
    clk_out_d   = clk_out_q;
    rd_d        = rd_q;
    ram_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d     = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        m_d     = byte_t'(prod_t'(k_q) % prod_t'(MOD_N));
        r_d     = 8'd1;
        i_d     = 3'd7;
        state_d = ST_SQR;
      end
      ST_SQR: begin
        r_d     = mm_y;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        if (EXP[i_q]) r_d = mm_y;
        if (i_q == 3'd0) begin
          state_d = ST_STORE;
        end else begin
          i_d     = i_q - 3'd1;
          state_d = ST_SQR;
        end
      end
      ST_STORE: begin
        ram_we      = 1'b1;
        flag_zero_d = (r_q == 8'd0);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ST_SEND_HI;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_SEND_HI: begin
        com_d     = 1'b1;
        clk_out_d = 1'b1;
        rd_d      = ram_q[k_q];
        state_d   = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        clk_out_d = 1'b0;
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = ST_SEND_HI;
        end
      end
      ST_DONE: begin
        end_d = 1'b1;
        com_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      i_q         <= 3'd0;
      flag_zero_q <= 1'b0;
      end_q       <= 1'b0;
      com_q       <= 1'b0;
      clk_out_q   <= 1'b0;
      rd_q        <= 8'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      i_q         <= i_d;
      flag_zero_q <= flag_zero_d;
      end_q       <= end_d;
      com_q       <= com_d;
      clk_out_q   <= clk_out_d;
      rd_q        <= rd_d;
    end
  end

  // Working operands and result RAM carry no reset; LOAD and STORE always overwrite them before use.
  always_ff @(posedge clk_FPGA) begin
    r_q <= r_d;
    m_q <= m_d;
    if (ram_we) ram_q[k_q] <= r_q;
  end

  assign FlagZero    = flag_zero_q;
  assign EndFlag     = end_q;
  assign COMFlag     = com_q;
  assign clk_out     = clk_out_q;
  assign ReadDataOut = rd_q;

endmodule

// File: tb/tb_rsa_pipeline_top.sv
// Directed self-checking bench for rsa_pipeline_top (encrypt by default, decrypt with RSA_DECRYPT_EN).
module tb_rsa_pipeline_top;

`ifdef RSA_DECRYPT_EN
  localparam int NB   = 256;
  localparam int EXPV = 63;
`else
  localparam int NB   = 16;
  localparam int EXPV = 7;
`endif
  localparam int MODV  = 253;
  localparam int FIRST = 18 * NB + 1;
  localparam int ENDAT = FIRST + 2 * NB;

  logic       clk_FPGA = 1'b0;
  logic       reset;
  logic       start;
  logic       FlagZero, EndFlag, COMFlag, clk_out;
  logic [7:0] ReadDataOut;

  int total = 0;
  int bad   = 0;
  logic [7:0] got       [NB];
  logic [7:0] first_run [NB];

  always #5 clk_FPGA = ~clk_FPGA;

  rsa_pipeline_top #(.N_BYTES(NB)) dut (
    .clk_FPGA    (clk_FPGA),
    .reset       (reset),
    .start       (start),
    .FlagZero    (FlagZero),
    .EndFlag     (EndFlag),
    .COMFlag     (COMFlag),
    .clk_out     (clk_out),
    .ReadDataOut (ReadDataOut)
  );

  function automatic logic [7:0] powmod(input int base, input int e);
    int acc;
    acc = 1;
    for (int j = 0; j < e; j++) acc = (acc * (base % MODV)) % MODV;
    return 8'(acc);
  endfunction

  task automatic test_reset;
    logic [11:0] obs;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk_FPGA);
    obs = {FlagZero, EndFlag, COMFlag, clk_out, ReadDataOut};
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=000", obs);
    end
    reset = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_FPGA);
      obs = {FlagZero, EndFlag, COMFlag, clk_out, ReadDataOut};
      total++;
      if (obs !== 12'h000) begin
        bad++;
        $display("FAIL idle_outputs cycle=%0d got=%h want=000", n, obs);
      end
    end
  endtask

  task automatic test_reset_mid_compute;
    logic [11:0] obs;
    start = 1'b1;
    @(posedge clk_FPGA);
    for (int n = 0; n < 25; n++) begin
      @(negedge clk_FPGA);
      if (n == 18) begin
        total++;
        if (FlagZero !== 1'b1) begin
          bad++;
          $display("FAIL abort_run_flagzero got=%b want=1", FlagZero);
        end
      end
    end
    #2 reset = 1'b0;
    #1;
    obs = {FlagZero, EndFlag, COMFlag, clk_out, ReadDataOut};
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL async_clear_compute got=%h want=000", obs);
    end
    @(negedge clk_FPGA);
    reset = 1'b1;
  endtask

  task automatic test_stream(input bit save);
    int first_hi, prev_hi, pulses, com_cnt, end_at;
    logic [7:0] last;
    first_hi = -1; prev_hi = -1; pulses = 0; com_cnt = 0; end_at = -1; last = 8'd0;
    start = 1'b1;
    @(posedge clk_FPGA);
    for (int n = 0; n <= ENDAT + 4; n++) begin
      @(negedge clk_FPGA);
      if (n == 18) begin
        total++;
        if (FlagZero !== 1'b1) begin
          bad++;
          $display("FAIL flagzero_byte0 got=%b want=1", FlagZero);
        end
      end
      if (n == 36) begin
        total++;
        if (FlagZero !== 1'b0) begin
          bad++;
          $display("FAIL flagzero_byte1 got=%b want=0", FlagZero);
        end
      end
      if (clk_out === 1'b1) begin
        if (first_hi < 0) first_hi = n;
        else begin
          total++;
          if (n - prev_hi !== 2) begin
            bad++;
            $display("FAIL pulse_spacing at=%0d got=%0d want=2", n, n - prev_hi);
          end
        end
        prev_hi = n;
        if (pulses < NB) got[pulses] = ReadDataOut;
        pulses++;
        last = ReadDataOut;
      end else if (COMFlag === 1'b1) begin
        total++;
        if (ReadDataOut !== last) begin
          bad++;
          $display("FAIL data_hold at=%0d got=%0d want=%0d", n, ReadDataOut, last);
        end
      end
      if (COMFlag === 1'b1) com_cnt++;
      if (EndFlag === 1'b1 && end_at < 0) end_at = n;
    end
    total++;
    if (first_hi !== FIRST) begin
      bad++;
      $display("FAIL first_pulse got=%0d want=%0d", first_hi, FIRST);
    end
    total++;
    if (pulses !== NB) begin
      bad++;
      $display("FAIL pulse_count got=%0d want=%0d", pulses, NB);
    end
    total++;
    if (com_cnt !== 2 * NB) begin
      bad++;
      $display("FAIL comflag_len got=%0d want=%0d", com_cnt, 2 * NB);
    end
    total++;
    if (end_at !== ENDAT) begin
      bad++;
      $display("FAIL endflag_rise got=%0d want=%0d", end_at, ENDAT);
    end
`ifdef RSA_DECRYPT_EN
    total++;
    if (got[128] !== 8'd2) begin
      bad++;
      $display("FAIL dec_byte128 got=%0d want=2", got[128]);
    end
    total++;
    if (got[163] !== 8'd3) begin
      bad++;
      $display("FAIL dec_byte163 got=%0d want=3", got[163]);
    end
    total++;
    if (got[0] !== 8'd0) begin
      bad++;
      $display("FAIL dec_byte0 got=%0d want=0", got[0]);
    end
`else
    begin
      logic [7:0] hand [5];
      hand = '{8'd0, 8'd1, 8'd128, 8'd163, 8'd192};
      for (int k = 0; k < 5; k++) begin
        total++;
        if (got[k] !== hand[k]) begin
          bad++;
          $display("FAIL enc_byte%0d got=%0d want=%0d", k, got[k], hand[k]);
        end
      end
    end
`endif
    for (int k = 0; k < NB; k++) begin
      total++;
      if (got[k] !== powmod(k, EXPV)) begin
        bad++;
        $display("FAIL model_byte%0d got=%0d want=%0d", k, got[k], powmod(k, EXPV));
      end
      if (save) first_run[k] = got[k];
      else begin
        total++;
        if (got[k] !== first_run[k]) begin
          bad++;
          $display("FAIL rerun_byte%0d got=%0d want=%0d", k, got[k], first_run[k]);
        end
      end
    end
  endtask

  task automatic test_end_sticky;
    logic [2:0] obs;
    start = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk_FPGA);
      obs = {EndFlag, COMFlag, clk_out};
      total++;
      if (obs !== 3'b100) begin
        bad++;
        $display("FAIL end_sticky cycle=%0d got=%b want=100", n, obs);
      end
    end
  endtask

  task automatic test_abort_output;
    logic [11:0] obs;
    @(negedge clk_FPGA);
    reset = 1'b0;
    @(negedge clk_FPGA);
    total++;
    if (EndFlag !== 1'b0) begin
      bad++;
      $display("FAIL endflag_cleared got=%b want=0", EndFlag);
    end
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk_FPGA);
    for (int n = 0; n <= FIRST + 10; n++) @(negedge clk_FPGA);
    total++;
    if (COMFlag !== 1'b1) begin
      bad++;
      $display("FAIL comflag_in_output got=%b want=1", COMFlag);
    end
    #2 reset = 1'b0;
    #1;
    obs = {FlagZero, EndFlag, COMFlag, clk_out, ReadDataOut};
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL async_clear_output got=%h want=000", obs);
    end
    @(negedge clk_FPGA);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_reset_mid_compute();
    test_stream(1'b1);
    test_end_sticky();
    test_abort_output();
    test_stream(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
